stream_decoder: RTL and testbench
=================================

STREAM_DECODER -- requirements
Module: stream_decoder

Interface
REQ-001 The block SHALL have parameter W, default 2: width of the binary input code.
REQ-002 The block SHALL have parameter N, fixed at 2**W: width of the one-hot output; it SHALL NOT be overridden.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream presents a code.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a code.
REQ-007 The block SHALL have port in_code, input, W bits: binary index to decode.
REQ-008 The block SHALL have port in_en, input, 1 bit: decode enable, sampled with in_code.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_y holds a decoded word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_y.
REQ-011 The block SHALL have port out_y, output, N bits: one-hot decoded word, registered.
REQ-012 The block SHALL have port xfer_cnt, output, 8 bits: count of completed output transfers.

Function
REQ-013 Input accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; output transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-014 On accept, the stored word SHALL be (1 << in_code) when in_en=1 and all-zeros when in_en=0; no other values are legal.
REQ-015 The block SHALL buffer up to 2 decoded words in FIFO order (head, tail).
REQ-016 The occupancy FSM SHALL have states EMPTY, ONE and FULL.
REQ-017 EMPTY SHALL go to ONE on accept, and otherwise stay EMPTY.
REQ-018 ONE SHALL go to FULL on accept without transfer, to EMPTY on transfer without accept, and stay ONE on simultaneous accept and transfer, with the new word becoming head.
REQ-019 FULL SHALL go to ONE on transfer, with tail moving to head, and otherwise stay FULL.
REQ-020 in_ready SHALL be 1 exactly when rst=0 and state != FULL; it SHALL NOT depend combinationally on out_ready or in_valid.
REQ-021 out_valid SHALL be 1 exactly when state != EMPTY; out_y SHALL always equal the head register.
REQ-022 Latency SHALL be one cycle: a code accepted at edge k into EMPTY SHALL appear on out_y with out_valid=1 immediately after edge k.
REQ-023 While out_valid=1 and out_ready=0, out_y SHALL hold stable and out_valid SHALL stay 1.
REQ-024 in_valid asserted while in_ready=0 SHALL have no effect; no word SHALL be dropped or duplicated.
REQ-025 out_ready asserted while out_valid=0 SHALL have no effect and SHALL NOT change xfer_cnt.
REQ-026 xfer_cnt SHALL increment by 1 on each output transfer and SHALL wrap from 255 to 0.
REQ-027 Full-rate streaming SHALL be supported: with in_valid=out_ready=1 continuously, one word SHALL pass per cycle.

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL set state=EMPTY, head=0, tail=0 and xfer_cnt=0; consequently out_valid=0, out_y=0 and in_ready=0.
REQ-029 Reset SHALL take priority over any simultaneous accept or transfer.
REQ-030 Reset asserted mid-operation SHALL discard all buffered words.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-032 Decode sweep: W=2, out_ready=1, in_en=1, in_code=0,1,2,3 on consecutive cycles -> out_y=0001,0010,0100,1000 one cycle later each; xfer_cnt=4.
REQ-033 Enable off: in_code=2, in_en=0 -> out_y=0000 with out_valid=1; a transfer still increments xfer_cnt.
REQ-034 Backpressure: out_ready=0, offer codes 1,3,0 -> first two accepted, in_ready=0 after the second, out_y holds 0010; raise out_ready -> 0010, 1000, 0001 delivered in order, no loss.
REQ-035 Simultaneous push/pop in ONE: head=0100, accept code 0 while transferring -> state stays ONE, out_y=0001 next cycle.
REQ-036 Wrap and reset: 256 transfers -> xfer_cnt=0; then with FULL, assert rst for one cycle -> out_valid=0, out_y=0, in_ready=1 the cycle after deassertion.

Source files
------------

// File: rtl/stream_decoder.sv
// Binary-to-one-hot decoder with a two-entry ready/valid output buffer
// and a wrapping count of completed output transfers.
module stream_decoder #(
  parameter  int W = 2,
  localparam int N = 2 ** W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_code,
  input  logic         in_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y,
  output logic [7:0]   xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [N-1:0] decode(input logic [W-1:0] code, input logic en);
    logic [N-1:0] word;
    word = '0;
    if (en) begin
      word[code] = 1'b1;
    end else begin
      word = '0;
    end
    return word;
  endfunction

  state_t       state_q, state_d;
  logic [N-1:0] head_q, head_d;
  logic [N-1:0] tail_q, tail_d;
  logic [7:0]   xfer_cnt_q, xfer_cnt_d;
  logic         accept_s;
  logic         xfer_s;
  logic [N-1:0] word_s;

  assign in_ready  = !rst && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_y     = head_q;
  assign xfer_cnt  = xfer_cnt_q;

  assign accept_s = in_valid && in_ready;
  assign xfer_s   = out_valid && out_ready;
  assign word_s   = decode(in_code, in_en);

  // Next-state and buffer movement; pop happens before push so a word
  // accepted during a transfer in ONE lands directly in head.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (xfer_s) begin
      xfer_cnt_d = xfer_cnt_q + 8'd1;
    end else begin
      xfer_cnt_d = xfer_cnt_q;
    end
    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          head_d  = word_s;
          state_d = ONE;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && xfer_s) begin
          head_d  = word_s;
          state_d = ONE;
        end else if (accept_s) begin
          tail_d  = word_s;
          state_d = FULL;
        end else if (xfer_s) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      FULL: begin
        if (xfer_s) begin
          head_d  = tail_q;
          state_d = ONE;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State, buffer and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      xfer_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_decoder.sv
// Self-checking bench for stream_decoder: directed scenarios plus random
// traffic, checked against a queue-based model of the two-word buffer.
module tb_stream_decoder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_code;
  logic       in_en;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_y;
  logic [7:0] xfer_cnt;

  int errors = 0;
  int checks = 0;

  logic [3:0] m_q[$];
  logic [3:0] m_head;
  logic [7:0] m_cnt;

  stream_decoder #(.W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .in_en    (in_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model; called with inputs applied.
  task automatic check_model();
    check("in_ready", 32'(in_ready), 32'(!rst && (m_q.size() < 2)));
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    check("out_y", 32'(out_y), 32'(m_head));
    check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
  endtask

  // One clock cycle: apply inputs at the falling edge, check, then advance
  // the model at the rising edge.
  task automatic step(input logic r, input logic iv, input logic en,
                      input logic [1:0] code, input logic ordy);
    logic acc;
    logic xf;
    logic [3:0] word;
    rst = r; in_valid = iv; in_en = en; in_code = code; out_ready = ordy;
    #1;
    check_model();
    acc  = iv && !r && (m_q.size() < 2);
    xf   = ordy && (m_q.size() > 0);
    word = en ? (4'd1 << code) : 4'd0;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_head = 4'd0;
      m_cnt  = 8'd0;
    end else begin
      if (xf) begin
        void'(m_q.pop_front());
        m_cnt = m_cnt + 8'd1;
      end
      if (acc) m_q.push_back(word);
      if (m_q.size() > 0) m_head = m_q[0];
    end
    @(negedge clk);
  endtask

  initial begin
    m_head = 4'd0; m_cnt = 8'd0;
    rst = 1'b1; in_valid = 1'b0; in_en = 1'b0; in_code = 2'd0; out_ready = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b1, 1'b1, 2'd1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_y", 32'(out_y), 32'd0);

    // Decode sweep at full rate
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 2'(k), 1'b1);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    check("sweep_cnt", 32'(xfer_cnt), 32'd4);

    // Enable off yields all-zero word, still transferred
    step(1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
    check("en_off_valid", 32'(out_valid), 32'd1);
    check("en_off_y", 32'(out_y), 32'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    check("en_off_cnt", 32'(xfer_cnt), 32'd5);

    // Backpressure: third code refused until space frees up
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'd3, 1'b0);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    check("bp_hold_y", 32'(out_y), 32'h2);
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    check("bp_second_y", 32'(out_y), 32'h8);
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    check("bp_third_y", 32'(out_y), 32'h1);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    check("bp_cnt", 32'(xfer_cnt), 32'd8);

    // Simultaneous push and pop in ONE
    step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    check("pp_y", 32'(out_y), 32'h1);
    check("pp_valid", 32'(out_valid), 32'd1);
    check("pp_in_ready", 32'(in_ready), 32'd1);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom),
           2'($urandom), 1'($urandom));
    end

    // Counter wrap after 256 transfers
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 1'b1, 2'($urandom), 1'b1);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    check("wrap_cnt", 32'(xfer_cnt), 32'd0);

    // Reset while FULL discards both words
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 1'b1, 1'b1, 2'd3, 1'b1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
